// File: rtl/sram_mem_mn.sv
// Word-addressable M x KMAX flop array with byte-masked writes and a one-cycle registered read port.
// Build option: define SRAM_MEM_MN_RST_CLEAR_EN to clear the whole array asynchronously on rst.
module sram_mem_mn #(
  parameter int M               = 2,
  parameter int KMAX            = 2,
  parameter int DATA_W          = 32,
  parameter int BYTE_W          = DATA_W / 8,
  parameter int CONFLICT_POLICY = 1,
  localparam int ROW_W          = (M <= 1) ? 1 : $clog2(M),
  localparam int K_W            = (KMAX <= 1) ? 1 : $clog2(KMAX)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              w_en,
  input  logic              w_re,
  input  logic              w_we,
  input  logic [ROW_W-1:0]  w_row,
  input  logic [K_W-1:0]    w_k,
  input  logic [DATA_W-1:0] w_wdata,
  input  logic [BYTE_W-1:0] w_wmask,
  output logic [DATA_W-1:0] w_rdata,
  output logic              w_rvalid
);

  if ((BYTE_W * 8 != DATA_W) || (DATA_W % 8 != 0)) begin : g_bad_width
    $error("sram_mem_mn: DATA_W must equal 8*BYTE_W");
  end
  if ((CONFLICT_POLICY < 0) || (CONFLICT_POLICY > 2)) begin : g_bad_policy
    $error("sram_mem_mn: CONFLICT_POLICY must be 0, 1 or 2");
  end
  if ((M < 1) || (KMAX < 1)) begin : g_bad_size
    $error("sram_mem_mn: M and KMAX must be at least 1");
  end

  logic [DATA_W-1:0] mem [M][KMAX];

  logic              in_range;
  logic              rd_req;
  logic              wr_go;
  logic [DATA_W-1:0] old_word;
  logic [DATA_W-1:0] merged;
  logic [DATA_W-1:0] rd_word;

  assign in_range = (int'(w_row) < M) && (int'(w_k) < KMAX);
  assign rd_req   = w_en && w_re;
  // Read priority drops the write of a combined request; rst gating keeps
  // requests out while reset is held even when the array itself is not reset.
  assign wr_go    = rst && w_en && w_we && in_range &&
                    !((CONFLICT_POLICY == 2) && w_re);

  always_comb begin
    old_word = '0;
    if (in_range) old_word = mem[w_row][w_k];
  end

  always_comb begin
    merged = old_word;
    for (int i = 0; i < BYTE_W; i++) begin
      if (w_wmask[i]) merged[8*i +: 8] = w_wdata[8*i +: 8];
    end
  end

  always_comb begin
    rd_word = '0;
    if (in_range) begin
      if ((CONFLICT_POLICY == 1) && w_we) rd_word = merged;
      else                                rd_word = old_word;
    end
  end

`ifdef SRAM_MEM_MN_RST_CLEAR_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < M; r++) begin
        for (int k = 0; k < KMAX; k++) begin
          mem[r][k] <= '0;
        end
      end
    end else if (wr_go) begin
      mem[w_row][w_k] <= merged;
    end
  end
`else
  // No reset on the array so it can map onto SRAM/LUTRAM.
  always_ff @(posedge clk) begin
    if (wr_go) mem[w_row][w_k] <= merged;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_rdata  <= '0;
      w_rvalid <= 1'b0;
    end else begin
      w_rvalid <= rd_req;
      if (rd_req) w_rdata <= rd_word;
    end
  end

endmodule

// File: tb/tb_sram_mem_mn.sv
// Scoreboard bench: three 3x4 instances (one per conflict policy) share stimulus;
// a negedge monitor pops expected read responses and checks rvalid timing and data.
module tb_sram_mem_mn;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        w_en = 1'b0, w_re = 1'b0, w_we = 1'b0;
  logic [1:0]  w_row = '0, w_k = '0;
  logic [31:0] w_wdata = '0;
  logic [3:0]  w_wmask = '0;
  logic [31:0] rd0, rd1, rd2;
  logic        rv0, rv1, rv2;

  sram_mem_mn #(.M(3), .KMAX(4), .DATA_W(32), .CONFLICT_POLICY(0)) u_p0 (
    .clk(clk), .rst(rst), .w_en(w_en), .w_re(w_re), .w_we(w_we), .w_row(w_row),
    .w_k(w_k), .w_wdata(w_wdata), .w_wmask(w_wmask), .w_rdata(rd0), .w_rvalid(rv0));
  sram_mem_mn #(.M(3), .KMAX(4), .DATA_W(32), .CONFLICT_POLICY(1)) u_p1 (
    .clk(clk), .rst(rst), .w_en(w_en), .w_re(w_re), .w_we(w_we), .w_row(w_row),
    .w_k(w_k), .w_wdata(w_wdata), .w_wmask(w_wmask), .w_rdata(rd1), .w_rvalid(rv1));
  sram_mem_mn #(.M(3), .KMAX(4), .DATA_W(32), .CONFLICT_POLICY(2)) u_p2 (
    .clk(clk), .rst(rst), .w_en(w_en), .w_re(w_re), .w_we(w_we), .w_row(w_row),
    .w_k(w_k), .w_wdata(w_wdata), .w_wmask(w_wmask), .w_rdata(rd2), .w_rvalid(rv2));

  typedef struct {
    logic [31:0] d0;
    logic [31:0] d1;
    logic [31:0] d2;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [31:0] pat(input int r, input int k);
    logic [15:0] lo;
    lo = 16'hA55A ^ 16'(r * 16 + k);
    return {r[7:0], k[7:0], lo};
  endfunction

  // Monitor: a response is due exactly at the cycle recorded when its request was sampled.
  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      n_chk++;
      $display("FAIL rvalid_missing: response due cycle %0d not seen by cycle %0d", e.cyc, cyc);
    end
    if (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      chk("rvalid_p0", 32'(rv0), 32'd1);
      chk("rvalid_p1", 32'(rv1), 32'd1);
      chk("rvalid_p2", 32'(rv2), 32'd1);
      chk("rdata_p0", rd0, e.d0);
      chk("rdata_p1", rd1, e.d1);
      chk("rdata_p2", rd2, e.d2);
    end else begin
      chk("rvalid_idle_p0", 32'(rv0), 32'd0);
      chk("rvalid_idle_p1", 32'(rv1), 32'd0);
      chk("rvalid_idle_p2", 32'(rv2), 32'd0);
    end
  end

  task automatic req(input logic re, input logic we, input int row, input int k,
                     input logic [31:0] wd, input logic [3:0] m,
                     input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2);
    w_en = 1'b1; w_re = re; w_we = we;
    w_row = 2'(row); w_k = 2'(k); w_wdata = wd; w_wmask = m;
    @(posedge clk);
    #1;
    if (re) q.push_back('{d0: e0, d1: e1, d2: e2, cyc: cyc});
  endtask

  task automatic wr(input int row, input int k, input logic [31:0] wd, input logic [3:0] m);
    req(1'b0, 1'b1, row, k, wd, m, '0, '0, '0);
  endtask

  task automatic rd(input int row, input int k, input logic [31:0] e);
    req(1'b1, 1'b0, row, k, '0, '0, e, e, e);
  endtask

  task automatic idle(input int n);
    w_en = 1'b0; w_re = 1'b0; w_we = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rvalid_p0"}, 32'(rv0), 32'd0);
    chk({tag, "_rvalid_p1"}, 32'(rv1), 32'd0);
    chk({tag, "_rvalid_p2"}, 32'(rv2), 32'd0);
    chk({tag, "_rdata_p0"}, rd0, 32'd0);
    chk({tag, "_rdata_p1"}, rd1, 32'd0);
    chk({tag, "_rdata_p2"}, rd2, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] e_after_rst;
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    @(negedge clk) rst = 1'b1;

    // Full fill, then stream every cell back.
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < 4; k++)
        wr(r, k, pat(r, k), 4'hF);
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < 4; k++)
        rd(r, k, pat(r, k));
    rd(1, 1, 32'h0101A54B);
    idle(1);

    // Byte mask
    wr(0, 0, 32'h11223344, 4'hF);
    wr(0, 0, 32'hAABBCCDD, 4'hC);
    rd(0, 0, 32'hAABB3344);
    rd(0, 1, pat(0, 1));
    wr(0, 3, 32'h99999999, 4'h0);
    rd(0, 3, pat(0, 3));
    idle(2);

    // Conflict per policy
    wr(1, 0, 32'h00000000, 4'hF);
    req(1'b1, 1'b1, 1, 0, 32'hDEADBEEF, 4'hF, 32'h00000000, 32'hDEADBEEF, 32'h00000000);
    req(1'b1, 1'b0, 1, 0, '0, '0, 32'hDEADBEEF, 32'hDEADBEEF, 32'h00000000);
    // Partial-mask conflict on (1,1): write-first returns merged word
    req(1'b1, 1'b1, 1, 1, 32'h12345678, 4'h3, 32'h0101A54B, 32'h01015678, 32'h0101A54B);
    req(1'b1, 1'b0, 1, 1, '0, '0, 32'h01015678, 32'h01015678, 32'h0101A54B);
    idle(1);

    // Out of range row 3
    wr(3, 0, 32'hFFFFFFFF, 4'hF);
    rd(3, 0, 32'h00000000);
    req(1'b1, 1'b0, 0, 0, '0, '0, 32'hAABB3344, 32'hAABB3344, 32'hAABB3344);
    req(1'b1, 1'b0, 1, 0, '0, '0, 32'hDEADBEEF, 32'hDEADBEEF, 32'h00000000);
    rd(2, 0, pat(2, 0));

    // No request: rvalid low, rdata held, disabled write ignored
    w_en = 1'b0; w_re = 1'b1; w_we = 1'b1; w_row = 2'd2; w_k = 2'd0;
    w_wdata = 32'h0; w_wmask = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    w_en = 1'b1; w_re = 1'b0; w_we = 1'b0;
    @(posedge clk);
    #1;
    chk("hold_p0", rd0, pat(2, 0));
    chk("hold_p1", rd1, pat(2, 0));
    chk("hold_p2", rd2, pat(2, 0));
    rd(2, 0, pat(2, 0));
    idle(1);

    // Reset between request edge and rvalid cycle; requests during reset ignored
    w_en = 1'b1; w_re = 1'b1; w_we = 1'b0; w_row = 2'd0; w_k = 2'd1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk_reset_outputs("midread");
    w_en = 1'b1; w_re = 1'b1; w_we = 1'b1; w_row = 2'd0; w_k = 2'd2;
    w_wdata = 32'h12345678; w_wmask = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    w_en = 1'b0; w_re = 1'b0; w_we = 1'b0;
    @(negedge clk) rst = 1'b1;
`ifdef SRAM_MEM_MN_RST_CLEAR_EN
    e_after_rst = 32'h0;
    rd(0, 2, 32'h0);
    rd(0, 1, 32'h0);
    rd(0, 0, 32'h0);
    rd(2, 3, 32'h0);
`else
    e_after_rst = pat(0, 2);
    rd(0, 2, pat(0, 2));
    rd(0, 1, pat(0, 1));
    rd(0, 0, 32'hAABB3344);
    rd(2, 3, pat(2, 3));
`endif
    idle(4);
    chk("post_reset_last_p0", rd0, e_after_rst == 32'h0 ? 32'h0 : pat(2, 3));

    n_chk++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL pending_responses: %0d left, required 0", q.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
